cluster_alloc_ctrl: RTL and testbench
=====================================

Name: cluster_alloc_ctrl

Overview:
- Sits directly upstream of the cluster L1 ring-buffer allocator, on the task path from the packet scheduler to the cluster.
- Accepts tasks carrying an ID and a byte size and requests buffer space from the allocator, retrying until granted.
- Forwards each task downstream tagged with its L1 offset and records the grant in a per-ID table.
- On handler completion, looks up the recorded index and size and issues the matching free to the allocator.

Parameters:
- BuffMemLength, 65536, allocator region size in bytes; index width is $clog2(BuffMemLength), size width is $clog2(BuffMemLength)+1.
- NumTaskIds, 16, number of task IDs that may be outstanding; ID width is $clog2(NumTaskIds).
- MaxTaskSize, 4096, largest legal task_size_i in bytes; must be <= BuffMemLength.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- task_valid_i  in  1  upstream task valid.
- task_ready_o  out  1  upstream task ready.
- task_id_i  in  IDW  task ID.
- task_size_i  in  SZW  task size in bytes.
- task_valid_o  out  1  downstream task valid.
- task_ready_i  in  1  downstream task ready.
- task_id_o  out  IDW  forwarded ID.
- task_addr_o  out  IXW  granted L1 byte offset.
- alloc_valid_o  out  1  allocation request.
- alloc_ready_i  in  1  allocator grant; combinational from allocator, same cycle.
- alloc_size_o  out  SZW  requested bytes.
- alloc_index_i  in  IXW  granted byte index, valid when alloc_ready_i is high.
- free_valid_o  out  1  single-cycle free pulse.
- free_index_o  out  IXW  byte index to free.
- free_size_o  out  SZW  bytes to free.
- done_valid_i  in  1  handler completion valid.
- done_ready_o  out  1  completion ready; always 1.
- done_id_i  in  IDW  completed task ID.
- outstanding_o  out  IDW+1  number of valid table entries.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i high at a clock edge) forces:
  - FSM to IDLE.
  - All table valid bits to 0.
  - task_valid_o, alloc_valid_o, free_valid_o, err_o and outstanding_o to 0.
  - All data outputs to 0.
- Reset mid-operation abandons any pending request or task. The allocator must be reset in the same cycle; the bench guarantees this.
- FSM states: IDLE, ALLOC, OUT.
- IDLE:
  - task_ready_o = !busy[task_id_i].
  - On handshake, register the ID and eff_size = max(task_size_i, 1), then go to ALLOC.
  - If busy[task_id_i] is set, hold task_ready_o low (head-of-line stall); the task is not dropped.
- ALLOC:
  - alloc_valid_o = 1 and alloc_size_o = eff_size; both stay stable until the grant.
  - When alloc_ready_i is high: write table[id] = {valid=1, index=alloc_index_i, size=eff_size}, register task_addr_o = alloc_index_i, go to OUT.
  - With no grant, stay in ALLOC indefinitely.
- OUT:
  - task_valid_o = 1 with task_id_o and task_addr_o held stable.
  - On task_ready_i, go to IDLE.
- Latency: task accepted at edge t gives alloc_valid_o in cycle t+1 and task_valid_o at t+2 at the earliest. Peak rate is one task per 3 cycles.
- Completion:
  - done_ready_o is constantly 1.
  - On done_valid_i with table[done_id_i].valid: clear the valid bit at that edge. In the next cycle drive free_valid_o = 1 with the stored index and size for exactly one cycle.
  - At most one free is issued per cycle. Back-to-back completions produce back-to-back free pulses.
- Error: done_valid_i for an ID whose entry is not valid sets err_o (sticky until reset). No free is issued and no other state changes.
- Simultaneous events:
  - A table write (grant) and a clear (done) in the same cycle cannot target the same ID, because busy gates acceptance.
  - Writes and clears to different IDs both take effect.
- outstanding_o is +1 on a grant and -1 on a valid done; both in the same cycle leaves it unchanged. It saturates at NumTaskIds by construction.
- task_size_i > MaxTaskSize is undefined; an assertion fires in simulation.

Optional Feature:
- Macro: CLUSTER_ALLOC_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cycles_o (32 bits), reset to 0.
  - Increments every cycle spent in ALLOC with alloc_ready_i low; saturates at 2^32-1.
  - Adds output port peak_outstanding_o (IDW+1 bits), reset to 0, holding the maximum value outoutstanding_o has reached.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Decomposition:
- Package cluster_alloc_pkg holds:
  - task_id_t, byte index type and byte size type, all derived from the parameters.
  - alloc_entry_t struct {valid, index, size}.
  - State enum {IDLE, ALLOC, OUT}.
- Sub-module cluster_alloc_table owns the entry array, busy vector, outstanding counter and registered free pulse generation. It has one write port (grant) and one clear/read port (done).
- The FSM and handshakes stay in cluster_alloc_ctrl.

Test Plan (paired with allocator, BuffMemLength=4096, MemSlotSize=64):
- Reset, then task {id=3, size=100} -> alloc_size_o=100; task_valid_o at cycle t+2 with task_addr_o=0; outstanding_o=1.
- Tasks {id=0, 2048}, {id=1, 2048}, then {id=2, 64} -> id2 stalls in ALLOC until done id=0. The free pulse carries index 0, size 2048; then id2 is granted at addr 0.
- Task id=5 outstanding, second task id=5 offered -> task_ready_o stays 0 until done id=5; the free pulse appears exactly one cycle after the done.
- Done id=7 with nothing outstanding -> err_o=1 and stays set; free_valid_o stays 0; outstanding_o is unchanged.
- Task size 0 -> alloc_size_o=1; grant of one slot at addr 0; free_size_o=1 on completion.
- Reset asserted while in OUT with two IDs outstanding -> next cycle all outputs are 0 and outstanding_o=0; a new task id=0 is granted at addr 0.

Source files
------------

// File: rtl/cluster_alloc_pkg.sv
// rtl/cluster_alloc_pkg.sv - shared sizes, types and state encoding for the cluster allocation controller
package cluster_alloc_pkg;

  localparam int BuffMemLength = 65536;
  localparam int NumTaskIds    = 16;
  localparam int MaxTaskSize   = 4096;

  localparam int IXW = $clog2(BuffMemLength);
  localparam int SZW = IXW + 1;
  localparam int IDW = $clog2(NumTaskIds);

  typedef logic [IDW-1:0] task_id_t;
  typedef logic [IXW-1:0] byte_idx_t;
  typedef logic [SZW-1:0] byte_size_t;
  typedef logic [IDW:0]   id_cnt_t;

  typedef struct packed {
    logic       valid;
    byte_idx_t  index;
    byte_size_t size;
  } alloc_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    OUT   = 2'd2
  } state_e;

  // A zero-byte task still occupies one allocator slot so its free stays well formed.
  function automatic byte_size_t eff_size(byte_size_t s);
    return (s == '0) ? byte_size_t'(1) : s;
  endfunction

endpackage

// File: rtl/cluster_alloc_table.sv
// rtl/cluster_alloc_table.sv - per-ID grant table with outstanding count and registered free pulse
module cluster_alloc_table
  import cluster_alloc_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  task_id_t              wr_id_i,
  input  byte_idx_t             wr_index_i,
  input  byte_size_t            wr_size_i,
  input  logic                  clr_en_i,
  input  task_id_t              clr_id_i,
  output logic [NumTaskIds-1:0] busy_o,
  output id_cnt_t               outstanding_o,
  output logic                  free_valid_o,
  output byte_idx_t             free_index_o,
  output byte_size_t            free_size_o,
  output logic                  err_o
);

  alloc_entry_t table_q [NumTaskIds];
  id_cnt_t      outstanding_q, outstanding_d;
  logic         free_valid_q, free_valid_d;
  byte_idx_t    free_index_q, free_index_d;
  byte_size_t   free_size_q, free_size_d;
  logic         err_q, err_d;
  logic         clr_hit;

  assign clr_hit = clr_en_i && table_q[clr_id_i].valid;

  // Expose the valid bits so the FSM can hold back tasks whose ID is still in use.
  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NumTaskIds; i++) busy_o[i] = table_q[i].valid;
  end

  // Next-state for the counter, the one-cycle free pulse and the sticky error.
  always_comb begin
    outstanding_d = outstanding_q;
    if (wr_en_i && !clr_hit)      outstanding_d = outstanding_q + id_cnt_t'(1);
    else if (!wr_en_i && clr_hit) outstanding_d = outstanding_q - id_cnt_t'(1);
    free_valid_d = clr_hit;
    free_index_d = clr_hit ? table_q[clr_id_i].index : '0;
    free_size_d  = clr_hit ? table_q[clr_id_i].size  : '0;
    err_d        = err_q || (clr_en_i && !clr_hit);
  end

  // Table and output registers; a grant and a clear never hit the same ID.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumTaskIds; i++) table_q[i] <= '0;
      outstanding_q <= '0;
      free_valid_q  <= 1'b0;
      free_index_q  <= '0;
      free_size_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      if (wr_en_i) table_q[wr_id_i] <= '{valid: 1'b1, index: wr_index_i, size: wr_size_i};
      if (clr_hit) table_q[clr_id_i].valid <= 1'b0;
      outstanding_q <= outstanding_d;
      free_valid_q  <= free_valid_d;
      free_index_q  <= free_index_d;
      free_size_q   <= free_size_d;
      err_q         <= err_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign free_valid_o  = free_valid_q;
  assign free_index_o  = free_index_q;
  assign free_size_o   = free_size_q;
  assign err_o         = err_q;

endmodule

// File: rtl/cluster_alloc_ctrl.sv
// rtl/cluster_alloc_ctrl.sv - task allocation FSM; CLUSTER_ALLOC_STALL_CNT_EN adds stall/peak counters
module cluster_alloc_ctrl
  import cluster_alloc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       task_valid_i,
  output logic       task_ready_o,
  input  task_id_t   task_id_i,
  input  byte_size_t task_size_i,
  output logic       task_valid_o,
  input  logic       task_ready_i,
  output task_id_t   task_id_o,
  output byte_idx_t  task_addr_o,
  output logic       alloc_valid_o,
  input  logic       alloc_ready_i,
  output byte_size_t alloc_size_o,
  input  byte_idx_t  alloc_index_i,
  output logic       free_valid_o,
  output byte_idx_t  free_index_o,
  output byte_size_t free_size_o,
  input  logic       done_valid_i,
  output logic       done_ready_o,
  input  task_id_t   done_id_i,
  output id_cnt_t    outstanding_o,
  output logic       err_o
`ifdef CLUSTER_ALLOC_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output id_cnt_t     peak_outstanding_o
`endif
);

  state_e                state_q, state_d;
  task_id_t              id_q, id_d;
  byte_size_t            size_q, size_d;
  byte_idx_t             addr_q, addr_d;
  logic [NumTaskIds-1:0] busy;
  logic                  grant;

  assign done_ready_o = 1'b1;

  // Next-state and handshake outputs; task data is only presented while in OUT.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    size_d        = size_q;
    addr_d        = addr_q;
    grant         = 1'b0;
    task_ready_o  = 1'b0;
    task_valid_o  = 1'b0;
    task_id_o     = '0;
    task_addr_o   = '0;
    alloc_valid_o = 1'b0;
    alloc_size_o  = '0;
    case (state_q)
      IDLE: begin
        task_ready_o = !busy[task_id_i];
        if (task_valid_i && !busy[task_id_i]) begin
          id_d    = task_id_i;
          size_d  = eff_size(task_size_i);
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        alloc_valid_o = 1'b1;
        alloc_size_o  = size_q;
        if (alloc_ready_i) begin
          grant   = 1'b1;
          addr_d  = alloc_index_i;
          state_d = OUT;
        end
      end
      OUT: begin
        task_valid_o = 1'b1;
        task_id_o    = id_q;
        task_addr_o  = addr_q;
        if (task_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured task registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      size_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
    end
  end

  cluster_alloc_table u_table (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_en_i       (grant),
    .wr_id_i       (id_q),
    .wr_index_i    (alloc_index_i),
    .wr_size_i     (size_q),
    .clr_en_i      (done_valid_i),
    .clr_id_i      (done_id_i),
    .busy_o        (busy),
    .outstanding_o (outstanding_o),
    .free_valid_o  (free_valid_o),
    .free_index_o  (free_index_o),
    .free_size_o   (free_size_o),
    .err_o         (err_o)
  );

  // Oversized tasks are outside the contract with the scheduler.
  a_task_size: assert property (@(posedge clk_i) disable iff (rst_i)
    task_valid_i |-> (task_size_i <= byte_size_t'(MaxTaskSize)));

`ifdef CLUSTER_ALLOC_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  id_cnt_t     peak_q, peak_d;

  // Count cycles waiting on the allocator (saturating) and track the high-water mark.
  always_comb begin
    stall_d = stall_q;
    if (state_q == ALLOC && !alloc_ready_i && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
    peak_d = (outstanding_o > peak_q) ? outstanding_o : peak_q;
  end

  // Monitor registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      peak_q  <= '0;
    end else begin
      stall_q <= stall_d;
      peak_q  <= peak_d;
    end
  end

  assign stall_cycles_o     = stall_q;
  assign peak_outstanding_o = peak_q;
`endif

endmodule

// File: tb/tb_cluster_alloc_ctrl.sv
// tb/tb_cluster_alloc_ctrl.sv - self-checking bench with a slot-bitmap allocator and task-level reference model
module tb_cluster_alloc_ctrl;
  import cluster_alloc_pkg::*;

  localparam int Slot = 64;
  localparam int NSlots = 64;

  logic       clk;
  logic       rst_i;
  logic       task_valid_i, task_ready_o;
  task_id_t   task_id_i;
  byte_size_t task_size_i;
  logic       task_valid_o, task_ready_i;
  task_id_t   task_id_o;
  byte_idx_t  task_addr_o;
  logic       alloc_valid_o, alloc_ready_i;
  byte_size_t alloc_size_o;
  byte_idx_t  alloc_index_i;
  logic       free_valid_o;
  byte_idx_t  free_index_o;
  byte_size_t free_size_o;
  logic       done_valid_i, done_ready_o;
  task_id_t   done_id_i;
  id_cnt_t    outstanding_o;
  logic       err_o;
`ifdef CLUSTER_ALLOC_STALL_CNT_EN
  logic [31:0] stall_cycles_o;
  id_cnt_t     peak_outstanding_o;
`endif

  cluster_alloc_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
    .task_id_i(task_id_i), .task_size_i(task_size_i),
    .task_valid_o(task_valid_o), .task_ready_i(task_ready_i),
    .task_id_o(task_id_o), .task_addr_o(task_addr_o),
    .alloc_valid_o(alloc_valid_o), .alloc_ready_i(alloc_ready_i),
    .alloc_size_o(alloc_size_o), .alloc_index_i(alloc_index_i),
    .free_valid_o(free_valid_o), .free_index_o(free_index_o), .free_size_o(free_size_o),
    .done_valid_i(done_valid_i), .done_ready_o(done_ready_o), .done_id_i(done_id_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
`ifdef CLUSTER_ALLOC_STALL_CNT_EN
    , .stall_cycles_o(stall_cycles_o), .peak_outstanding_o(peak_outstanding_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- allocator environment: 4096 bytes as 64 slots, first fit ----------------
  logic [NSlots-1:0] slot_used, slot_next;
  int env_start;
  bit env_fit;

  function automatic bit find_fit(input int bytes, input logic [NSlots-1:0] used, output int start);
    int n;
    n = (bytes + Slot - 1) / Slot;
    for (int s = 0; s + n <= NSlots; s++) begin
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < n; k++) if (used[s+k]) ok = 1'b0;
      if (ok) begin
        start = s;
        return 1'b1;
      end
    end
    start = 0;
    return 1'b0;
  endfunction

  function automatic logic [NSlots-1:0] span_mask(input int idx, input int bytes);
    logic [NSlots-1:0] m;
    int s, n;
    m = '0;
    s = idx / Slot;
    n = (bytes + Slot - 1) / Slot;
    for (int k = 0; k < NSlots; k++) if (k >= s && k < s + n) m[k] = 1'b1;
    return m;
  endfunction

  always_comb begin
    env_start = 0;
    env_fit = find_fit(int'(alloc_size_o), slot_used, env_start);
    alloc_ready_i = alloc_valid_o && env_fit;
    alloc_index_i = (alloc_valid_o && env_fit) ? byte_idx_t'(env_start * Slot) : '0;
  end

  always_comb begin
    slot_next = slot_used;
    if (alloc_valid_o && alloc_ready_i) slot_next = slot_next | span_mask(int'(alloc_index_i), int'(alloc_size_o));
    if (free_valid_o) slot_next = slot_next & ~span_mask(int'(free_index_o), int'(free_size_o));
  end

  always @(posedge clk) slot_used <= rst_i ? '0 : slot_next;

  // ---------------- reference model: per-ID table plus a queue of the task in flight ----------------
  typedef struct {
    int id;
    int eff;
    int addr;
    bit granted;
  } pend_t;

  pend_t pend_q[$];
  bit    m_valid[NumTaskIds];
  int    m_idx[NumTaskIds];
  int    m_sz[NumTaskIds];
  bit    m_free_v;
  int    m_free_idx, m_free_sz;
  bit    m_err;
  bit    m_acc;
  bit    chk_en = 1'b0;

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NumTaskIds; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic check_outputs();
    bit exp_rdy, exp_av, exp_tv;
    int exp_sz, exp_id, exp_addr;
    exp_rdy = (pend_q.size() == 0) && !m_valid[task_id_i];
    exp_av = 1'b0; exp_tv = 1'b0; exp_sz = 0; exp_id = 0; exp_addr = 0;
    if (pend_q.size() != 0) begin
      if (!pend_q[0].granted) begin
        exp_av = 1'b1;
        exp_sz = pend_q[0].eff;
      end else begin
        exp_tv = 1'b1;
        exp_id = pend_q[0].id;
        exp_addr = pend_q[0].addr;
      end
    end
    chk("task_ready_o", task_ready_o, exp_rdy);
    chk("alloc_valid_o", alloc_valid_o, exp_av);
    chk("alloc_size_o", alloc_size_o, exp_sz);
    chk("task_valid_o", task_valid_o, exp_tv);
    chk("task_id_o", task_id_o, exp_id);
    chk("task_addr_o", task_addr_o, exp_addr);
    chk("free_valid_o", free_valid_o, m_free_v);
    chk("free_index_o", free_index_o, m_free_idx);
    chk("free_size_o", free_size_o, m_free_sz);
    chk("outstanding_o", outstanding_o, model_count());
    chk("err_o", err_o, m_err);
    chk("done_ready_o", done_ready_o, 1);
  endtask

  task automatic model_update();
    bit nf;
    int st;
    pend_t p;
    if (rst_i) begin
      pend_q.delete();
      for (int i = 0; i < NumTaskIds; i++) begin
        m_valid[i] = 1'b0; m_idx[i] = 0; m_sz[i] = 0;
      end
      m_free_v = 1'b0; m_free_idx = 0; m_free_sz = 0; m_err = 1'b0; m_acc = 1'b0;
      return;
    end
    m_acc = task_valid_i && (pend_q.size() == 0) && !m_valid[task_id_i];
    nf = 1'b0;
    m_free_idx = 0;
    m_free_sz = 0;
    if (done_valid_i) begin
      if (m_valid[done_id_i]) begin
        m_valid[done_id_i] = 1'b0;
        nf = 1'b1;
        m_free_idx = m_idx[done_id_i];
        m_free_sz = m_sz[done_id_i];
      end else begin
        m_err = 1'b1;
      end
    end
    m_free_v = nf;
    if (pend_q.size() != 0) begin
      p = pend_q[0];
      if (!p.granted) begin
        if (find_fit(p.eff, slot_used, st)) begin
          p.granted = 1'b1;
          p.addr = st * Slot;
          m_valid[p.id] = 1'b1;
          m_idx[p.id] = p.addr;
          m_sz[p.id] = p.eff;
          pend_q[0] = p;
        end
      end else if (task_ready_i) begin
        void'(pend_q.pop_front());
      end
    end
    if (m_acc) begin
      p.id = int'(task_id_i);
      p.eff = (task_size_i == '0) ? 1 : int'(task_size_i);
      p.addr = 0;
      p.granted = 1'b0;
      pend_q.push_back(p);
    end
  endtask

  // ---------------- cycle helpers ----------------
  task automatic sample();
    @(negedge clk);
    if (chk_en) check_outputs();
    model_update();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_reset();
    task_valid_i = 1'b0; task_ready_i = 1'b0; done_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic send(input int id, input int size);
    bit acc;
    acc = 1'b0;
    task_valid_i = 1'b1;
    task_id_i = task_id_t'(id);
    task_size_i = byte_size_t'(size);
    for (int i = 0; i < 200 && !acc; i++) begin
      sample();
      acc = m_acc;
      advance();
    end
    task_valid_i = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  // Leaves the caller at the negedge of the first cycle showing task_valid_o.
  task automatic wait_tv(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sample();
      if (task_valid_o) begin
        got = 1'b1;
        break;
      end
      advance();
    end
    if (!got) chk(name, 0, 1);
  endtask

  typedef struct {
    int id;
    int size;
    int exp_alloc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ids[$];
    int r;

    vecs[0] = '{id: 3,  size: 100,  exp_alloc: 100};
    vecs[1] = '{id: 0,  size: 0,    exp_alloc: 1};
    vecs[2] = '{id: 15, size: 4096, exp_alloc: 4096};
    vecs[3] = '{id: 7,  size: 64,   exp_alloc: 64};
    vecs[4] = '{id: 9,  size: 65,   exp_alloc: 65};
    vecs[5] = '{id: 12, size: 1,    exp_alloc: 1};

    rst_i = 1'b1;
    task_valid_i = 1'b0; task_id_i = '0; task_size_i = '0;
    task_ready_i = 1'b0; done_valid_i = 1'b0; done_id_i = '0;
    step();
    step();
    chk_en = 1'b1;
    rst_i = 1'b0;

    sample();
    chk("reset_task_valid", task_valid_o, 0);
    chk("reset_alloc_valid", alloc_valid_o, 0);
    chk("reset_free_valid", free_valid_o, 0);
    chk("reset_outstanding", outstanding_o, 0);
    chk("reset_err", err_o, 0);
    advance();

    // Single-task vectors, each from reset on an empty allocator.
    foreach (vecs[v]) begin
      do_reset();
      task_valid_i = 1'b1;
      task_id_i = task_id_t'(vecs[v].id);
      task_size_i = byte_size_t'(vecs[v].size);
      sample(); chk("vec_ready", task_ready_o, 1); advance();
      task_valid_i = 1'b0;
      task_ready_i = 1'b1;
      sample(); chk("vec_alloc_valid", alloc_valid_o, 1); chk("vec_alloc_size", alloc_size_o, vecs[v].exp_alloc); advance();
      sample(); chk("vec_task_valid", task_valid_o, 1); chk("vec_task_addr", task_addr_o, 0);
      chk("vec_task_id", task_id_o, vecs[v].id); chk("vec_outstanding", outstanding_o, 1); advance();
      task_ready_i = 1'b0;
      done_valid_i = 1'b1; done_id_i = task_id_t'(vecs[v].id);
      step();
      done_valid_i = 1'b0;
      sample(); chk("vec_free_valid", free_valid_o, 1); chk("vec_free_index", free_index_o, 0);
      chk("vec_free_size", free_size_o, vecs[v].exp_alloc); chk("vec_free_outstanding", outstanding_o, 0); advance();
      sample(); chk("vec_free_single", free_valid_o, 0); advance();
    end

    // Allocator full: third task waits in ALLOC until the first is freed.
    do_reset();
    task_ready_i = 1'b1;
    send(0, 2048);
    send(1, 2048);
    send(2, 64);
    repeat (5) step();
    done_valid_i = 1'b1; done_id_i = task_id_t'(0);
    sample(); chk("stall_alloc_valid", alloc_valid_o, 1); chk("stall_no_task", task_valid_o, 0); advance();
    done_valid_i = 1'b0;
    sample(); chk("stall_free_valid", free_valid_o, 1); chk("stall_free_index", free_index_o, 0);
    chk("stall_free_size", free_size_o, 2048); advance();
    wait_tv("stall_grant_timeout");
    chk("stall_task_id", task_id_o, 2); chk("stall_task_addr", task_addr_o, 0);
    advance();

    // Same ID offered while still outstanding: held until its completion.
    do_reset();
    task_ready_i = 1'b1;
    send(5, 128);
    repeat (3) step();
    task_valid_i = 1'b1; task_id_i = task_id_t'(5); task_size_i = byte_size_t'(64);
    repeat (3) begin
      sample(); chk("busy_stall", task_ready_o, 0); advance();
    end
    done_valid_i = 1'b1; done_id_i = task_id_t'(5);
    sample(); chk("busy_stall_done", task_ready_o, 0); advance();
    done_valid_i = 1'b0;
    sample(); chk("busy_free_next", free_valid_o, 1); chk("busy_ready_after", task_ready_o, 1); advance();
    task_valid_i = 1'b0;
    sample(); chk("busy_free_single", free_valid_o, 0); advance();
    repeat (4) step();

    // Completion for an ID with nothing outstanding.
    do_reset();
    done_valid_i = 1'b1; done_id_i = task_id_t'(7);
    step();
    done_valid_i = 1'b0;
    repeat (3) begin
      sample(); chk("err_sticky", err_o, 1); chk("err_no_free", free_valid_o, 0);
      chk("err_outstanding", outstanding_o, 0); advance();
    end

    // Reset while presenting a task with two IDs outstanding.
    do_reset();
    task_ready_i = 1'b1;
    send(1, 100);
    send(2, 200);
    task_ready_i = 1'b0;
    repeat (3) step();
    sample(); chk("rst_pre_task_valid", task_valid_o, 1); chk("rst_pre_outstanding", outstanding_o, 2); advance();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    sample();
    chk("rst_task_valid", task_valid_o, 0); chk("rst_task_id", task_id_o, 0); chk("rst_task_addr", task_addr_o, 0);
    chk("rst_alloc_valid", alloc_valid_o, 0); chk("rst_alloc_size", alloc_size_o, 0);
    chk("rst_free_valid", free_valid_o, 0); chk("rst_free_index", free_index_o, 0); chk("rst_free_size", free_size_o, 0);
    chk("rst_err", err_o, 0); chk("rst_outstanding", outstanding_o, 0);
    advance();
    task_ready_i = 1'b1;
    send(0, 64);
    wait_tv("rst_regrant_timeout");
    chk("rst_regrant_addr", task_addr_o, 0);
    advance();

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      task_valid_i = 1'($urandom_range(0, 1));
      task_id_i = task_id_t'($urandom_range(0, NumTaskIds - 1));
      r = $urandom_range(0, 9);
      task_size_i = (r == 0) ? byte_size_t'(0) : (r == 1) ? byte_size_t'(MaxTaskSize)
                  : byte_size_t'($urandom_range(1, 1024));
      task_ready_i = ($urandom_range(0, 3) != 0);
      ids.delete();
      for (int i = 0; i < NumTaskIds; i++) if (m_valid[i]) ids.push_back(i);
      done_valid_i = (ids.size() > 0) && ($urandom_range(0, 2) == 0);
      done_id_i = (ids.size() > 0) ? task_id_t'(ids[$urandom_range(0, ids.size() - 1)]) : '0;
      step();
    end
    task_valid_i = 1'b0; done_valid_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
